// File: rtl/rr_replay_unpacker.sv
// Replay-side unpacker: splits one packed rr_stream_bus_t logging unit into per-channel logb/loge handshakes.
// Optional build macro RR_UNPACK_LEN_CHECK_EN enables the sticky in_len consistency check on len_err.
package rr_replay_unpacker_pkg;
  function automatic int width_of(logic [255:0] cw, int i);
    return int'(cw[i*8 +: 8]);
  endfunction

  function automatic int sum_widths(logic [255:0] cw, int n);
    int s;
    s = 0;
    for (int i = 0; i < n; i++) s += width_of(cw, i);
    return s;
  endfunction

  function automatic int max_width(logic [255:0] cw, int n);
    int m;
    m = 1;
    for (int i = 0; i < n; i++) if (width_of(cw, i) > m) m = width_of(cw, i);
    return m;
  endfunction
endpackage

module rr_replay_unpacker
  import rr_replay_unpacker_pkg::*;
#(
  parameter int LOGB_CHANNEL_CNT = 4,
  parameter logic [8*LOGB_CHANNEL_CNT-1:0] CHANNEL_WIDTHS = {8'd8, 8'd16, 8'd64, 8'd32},
  parameter int LOGE_CHANNEL_CNT = 4,
  localparam int MAX_W        = max_width(256'(CHANNEL_WIDTHS), LOGB_CHANNEL_CNT),
  localparam int HDR_W        = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT,
  localparam int FULL_WIDTH   = sum_widths(256'(CHANNEL_WIDTHS), LOGB_CHANNEL_CNT) + HDR_W,
  localparam int OFFSET_WIDTH = $clog2(FULL_WIDTH + 1)
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [FULL_WIDTH-1:0]             in_data,
  input  logic [OFFSET_WIDTH-1:0]           in_len,
  output logic [LOGB_CHANNEL_CNT-1:0]       logb_valid,
  input  logic [LOGB_CHANNEL_CNT-1:0]       logb_ready,
  output logic [LOGB_CHANNEL_CNT*MAX_W-1:0] logb_data,
  output logic [LOGE_CHANNEL_CNT-1:0]       loge_valid,
  input  logic [LOGE_CHANNEL_CNT-1:0]       loge_ready,
  output logic [31:0]                       unit_cnt,
  output logic                              len_err
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] DISPATCH = 1'b1;

  logic [0:0]                        state_q, state_d;
  logic [LOGB_CHANNEL_CNT-1:0]       logb_vld_q, logb_vld_d;
  logic [LOGE_CHANNEL_CNT-1:0]       loge_vld_q, loge_vld_d;
  logic [LOGB_CHANNEL_CNT*MAX_W-1:0] data_q, data_d, data_ext;
  logic [31:0]                       unit_cnt_q, unit_cnt_d;
  logic [LOGB_CHANNEL_CNT-1:0]       hdr_b;
  logic [LOGE_CHANNEL_CNT-1:0]       hdr_e;
  logic [FULL_WIDTH-1:0]             shifted_c;
  int                                off_c;
  logic                              accept;

  function automatic logic [MAX_W-1:0] lane_mask(int w);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int b = 0; b < MAX_W; b++) if (b < w) m[b] = 1'b1;
    return m;
  endfunction

  assign hdr_b    = in_data[LOGB_CHANNEL_CNT-1:0];
  assign hdr_e    = in_data[LOGB_CHANNEL_CNT +: LOGE_CHANNEL_CNT];
  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready;

  // Absent channels occupy no payload bits, so each present channel starts where the previous one ended.
  // The final offset doubles as the expected unit length.
  always_comb begin
    off_c     = HDR_W;
    shifted_c = '0;
    data_ext  = '0;
    for (int i = 0; i < LOGB_CHANNEL_CNT; i++) begin
      if (hdr_b[i]) begin
        shifted_c = in_data >> off_c;
        data_ext[i*MAX_W +: MAX_W] = shifted_c[MAX_W-1:0] &
                                     lane_mask(width_of(256'(CHANNEL_WIDTHS), i));
        off_c = off_c + width_of(256'(CHANNEL_WIDTHS), i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    logb_vld_d = logb_vld_q;
    loge_vld_d = loge_vld_q;
    data_d     = data_q;
    unit_cnt_d = unit_cnt_q;
    if (accept) begin
      unit_cnt_d = unit_cnt_q + 32'd1;
      logb_vld_d = hdr_b;
      loge_vld_d = hdr_e;
      data_d     = data_ext;
      state_d    = (|{hdr_b, hdr_e}) ? DISPATCH : IDLE;
    end else if (state_q == DISPATCH) begin
      logb_vld_d = logb_vld_q & ~logb_ready;
      loge_vld_d = loge_vld_q & ~loge_ready;
      if ((logb_vld_d == '0) && (loge_vld_d == '0)) state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      logb_vld_q <= '0;
      loge_vld_q <= '0;
      data_q     <= '0;
      unit_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      logb_vld_q <= logb_vld_d;
      loge_vld_q <= loge_vld_d;
      data_q     <= data_d;
      unit_cnt_q <= unit_cnt_d;
    end
  end

`ifdef RR_UNPACK_LEN_CHECK_EN
  logic len_err_q;

  // Sticky: a bad length is flagged but the unit is still dispatched.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_err_q <= 1'b0;
    end else if (accept && (int'(in_len) != off_c)) begin
      len_err_q <= 1'b1;
    end
  end

  assign len_err = len_err_q;
`else
  logic unused_len;
  assign unused_len = ^in_len;
  assign len_err    = 1'b0;
`endif

  assign logb_valid = logb_vld_q;
  assign loge_valid = loge_vld_q;
  assign logb_data  = data_q;
  assign unit_cnt   = unit_cnt_q;

endmodule
